goertzel_bin_scheduler: RTL and testbench
=========================================

GOERTZEL_BIN_SCHEDULER -- requirements
Module: goertzel_bin_scheduler

Interface
REQ-001 SHALL have parameter NBINS, default 8, meaning the number of frequency bins swept per sweep (2..256).
REQ-002 SHALL have parameter BW, default 3, meaning the bin index width; BW = clog2(NBINS).
REQ-003 SHALL have parameter OW, default 18, meaning the Goertzel result width (signed, A(n,f)).
REQ-004 SHALL have parameter N, default 126, meaning the samples per Goertzel block.
REQ-005 SHALL have parameter TO, default 16, meaning the cycles of slack beyond N before a timeout is declared.
REQ-006 SHALL have port i_clk  in  1  meaning the sole clock; all logic is on its rising edge.
REQ-007 SHALL have port i_rst_n  in  1  meaning the reset, which is synchronous and active-low.
REQ-008 SHALL have port i_start  in  1  meaning a one-cycle pulse that begins a sweep; it is ignored unless in IDLE.
REQ-009 SHALL have port i_continuous  in  1  meaning restart at bin 0 after the last bin; it is sampled at the end of each sweep.
REQ-010 SHALL have port o_gz_rst  out  1  meaning the active-high synchronous reset to the Goertzel engine.
REQ-011 SHALL have port o_gz_bin  out  BW  meaning the bin index that configures the engine coefficient/phase step.
REQ-012 SHALL have port i_gz_valid  in  1  meaning the engine's result-valid flag.
REQ-013 SHALL have port i_gz_re / i_gz_im  in  OW each  meaning the engine result.
REQ-014 SHALL have port o_res_valid  out  1  meaning the output handshake valid; i_res_ready  in  1  is the output handshake ready.
REQ-015 SHALL have port o_res_bin  out  BW, o_res_re / o_res_im  out  OW, and o_res_mag  out  2*OW+1  meaning the captured result.
REQ-016 SHALL have port o_busy  out  1, o_done  out  1 (end-of-sweep pulse) and o_err  out  2 (sticky {timeout, overrun}).

Function
REQ-017 SHALL implement the states IDLE, CLEAR, RUN, HOLD and NEXT.
REQ-018 SHALL leave IDLE for CLEAR on i_start, with bin=0 and o_busy=1.
REQ-019 SHALL hold o_gz_rst=1 for exactly 2 cycles in CLEAR, with o_gz_bin stable at least 1 cycle before o_gz_rst deasserts, then enter RUN.
REQ-020 SHALL in RUN count cycles from 0; on i_gz_valid it SHALL capture re/im/bin into the output register and go to HOLD.
REQ-021 SHALL, when the RUN counter reaches N+TO without i_gz_valid, set o_err[1], capture re=im=0 and go to HOLD.
REQ-022 SHALL assert o_res_valid in HOLD; the transfer occurs when o_res_valid && i_res_ready, then NEXT.
REQ-023 SHALL hold o_res_* stable while o_res_valid=1 && i_res_ready=0.
REQ-024 SHALL, in NEXT, go to CLEAR with bin+1 if bin < NBINS-1; otherwise it SHALL pulse o_done for 1 cycle and go to CLEAR with bin=0 if i_continuous=1, else to IDLE with o_busy=0.
REQ-025 SHALL, on i_gz_valid outside RUN, set o_err[0] (overrun) and discard the result without disturbing the output register.
REQ-026 SHALL give a minimum per-bin latency of 2 (CLEAR) + engine latency + 1 (capture) + 1 (NEXT) cycles plus output stall.
REQ-027 SHALL clear o_err only by reset; i_start does not clear it.
REQ-028 SHALL ignore an i_start arriving in the same cycle as the last transfer.

Reset
REQ-029 SHALL, while i_rst_n=0 at a clock edge, enter IDLE with bin=0, o_gz_rst=1, o_res_valid=0, o_res_*=0, o_busy=0, o_done=0 and o_err=0.
REQ-030 SHALL, on reset mid-sweep, abandon the sweep with no o_done and no partial output; o_gz_rst remains 1 during reset and goes 0 the cycle after release.

Configuration
REQ-031 SHALL, with GZ_SCHED_MAGSQ_EN defined, compute o_res_mag = re*re + im*im (unsigned, full width) through one pipeline register, so that capture-to-o_res_valid becomes 2 cycles.
REQ-032 SHALL, without GZ_SCHED_MAGSQ_EN, drive o_res_mag constant 0, with capture-to-o_res_valid of 1 cycle.

Structure
REQ-033 SHALL place the state enum encoding, default parameters and the err bit positions (ERR_OVR=0, ERR_TO=1) in shared package goertzel_pkg.
REQ-034 SHALL place the squaring/sum datapath in one sub-module, gz_mag_sq, which is instantiated only under GZ_SCHED_MAGSQ_EN.

Verification
REQ-035 SHALL cover a single sweep: NBINS=4, engine model valid at N+3 after o_gz_rst falls, ready=1 -> 4 transfers with bins 0,1,2,3, o_done pulse once, o_busy=0 after.
REQ-036 SHALL cover backpressure: i_res_ready=0 for 20 cycles in HOLD, re=-5, im=7 -> o_res_* stable for 20 cycles and exactly 1 transfer.
REQ-037 SHALL cover timeout: engine never valid, N=126, TO=16 -> HOLD entered 142 cycles into RUN, re=im=0, o_err=2'b10.
REQ-038 SHALL cover overrun: an i_gz_valid pulse in HOLD -> o_err[0]=1 and the held output unchanged.
REQ-039 SHALL cover continuous mode: i_continuous=1 for 2 sweeps -> bin sequence 0..3,0..3 with 2 o_done pulses; dropping i_continuous before the 2nd end -> IDLE.
REQ-040 SHALL cover reset mid-RUN on bin 2: -> IDLE, no o_done, and the next i_start begins at bin 0; with GZ_SCHED_MAGSQ_EN, re=3, im=-4 -> o_res_mag=25.

Source files
------------

// File: rtl/goertzel_pkg.sv
// goertzel_pkg: shared scheduler state encoding, default parameters and error bit positions
package goertzel_pkg;
  localparam int NBINS_D = 8;
  localparam int BW_D = 3;
  localparam int OW_D = 18;
  localparam int N_D = 126;
  localparam int TO_D = 16;
  localparam int ERR_OVR = 0;
  localparam int ERR_TO = 1;
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_HOLD, S_NEXT} gz_state_e;
endpackage

// File: rtl/goertzel_bin_scheduler_if.sv
// goertzel_bin_scheduler_if: engine control/result bus plus the result valid/ready handshake
interface goertzel_bin_scheduler_if import goertzel_pkg::*; #(
  parameter int BW = BW_D,
  parameter int OW = OW_D
);
  logic o_gz_rst;
  logic [BW-1:0] o_gz_bin;
  logic i_gz_valid;
  logic signed [OW-1:0] i_gz_re, i_gz_im;
  logic o_res_valid, i_res_ready;
  logic [BW-1:0] o_res_bin;
  logic signed [OW-1:0] o_res_re, o_res_im;
  logic [2*OW:0] o_res_mag;
  modport master (
    output o_gz_rst, o_gz_bin, o_res_valid, o_res_bin, o_res_re, o_res_im, o_res_mag,
    input i_gz_valid, i_gz_re, i_gz_im, i_res_ready
  );
  modport slave (
    input o_gz_rst, o_gz_bin, o_res_valid, o_res_bin, o_res_re, o_res_im, o_res_mag,
    output i_gz_valid, i_gz_re, i_gz_im, i_res_ready
  );
endinterface

// File: rtl/gz_mag_sq.sv
// gz_mag_sq: registered re*re + im*im, only built when GZ_SCHED_MAGSQ_EN is defined
`ifdef GZ_SCHED_MAGSQ_EN
module gz_mag_sq #(
  parameter int OW = 18
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic signed [OW-1:0] i_re,
  input  logic signed [OW-1:0] i_im,
  output logic [2*OW:0] o_mag
);
  logic signed [2*OW-1:0] w_re_x, w_im_x, w_re2, w_im2;
  logic [2*OW:0] r_mag;
  assign w_re_x = $signed({{OW{i_re[OW-1]}}, i_re});
  assign w_im_x = $signed({{OW{i_im[OW-1]}}, i_im});
  assign w_re2 = w_re_x * w_re_x;
  assign w_im2 = w_im_x * w_im_x;
  always_ff @(posedge i_clk)
    r_mag <= !i_rst_n ? '0 : {1'b0, w_re2} + {1'b0, w_im2};
  assign o_mag = r_mag;
endmodule
`endif

// File: rtl/goertzel_bin_scheduler.sv
// goertzel_bin_scheduler: sweeps bins through a Goertzel engine and hands results out on valid/ready.
// Optional GZ_SCHED_MAGSQ_EN adds a pipelined |X|^2 output and one extra cycle before o_res_valid.
module goertzel_bin_scheduler import goertzel_pkg::*; #(
  parameter int NBINS = NBINS_D,
  parameter int BW = BW_D,
  parameter int OW = OW_D,
  parameter int N = N_D,
  parameter int TO = TO_D
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_start,
  input  logic i_continuous,
  goertzel_bin_scheduler_if.master bus,
  output logic o_busy,
  output logic o_done,
  output logic [1:0] o_err
);
  localparam int CW = $clog2(N + TO + 1);
  localparam logic [CW-1:0] C_TO = CW'(N + TO - 1);
  localparam logic [BW-1:0] B_LAST = BW'(NBINS - 1);
  gz_state_e r_state, w_state_n;
  logic [CW-1:0] r_cnt;
  logic [BW-1:0] r_bin, w_bin_n, r_res_bin;
  logic r_gz_rst;
  logic signed [OW-1:0] r_re, r_im;
  logic [1:0] r_err;
  logic w_last, w_cap, w_to, w_xfer, w_res_valid, w_mag_ok;
  assign w_last = r_bin == B_LAST;
  assign w_cap = r_state == S_RUN && bus.i_gz_valid;
  // timeout fires as the RUN counter would step onto N+TO
  assign w_to = r_state == S_RUN && !bus.i_gz_valid && r_cnt == C_TO;
  assign w_res_valid = r_state == S_HOLD && w_mag_ok;
  assign w_xfer = w_res_valid && bus.i_res_ready;
  always_comb begin
    w_state_n = r_state;
    w_bin_n = r_bin;
    case (r_state)
      S_IDLE: w_state_n = i_start ? S_CLEAR : S_IDLE;
      S_CLEAR: w_state_n = r_cnt == CW'(1) ? S_RUN : S_CLEAR;
      S_RUN: w_state_n = (w_cap || w_to) ? S_HOLD : S_RUN;
      S_HOLD: w_state_n = w_xfer ? S_NEXT : S_HOLD;
      S_NEXT: begin
        w_state_n = (w_last && !i_continuous) ? S_IDLE : S_CLEAR;
        w_bin_n = w_last ? '0 : r_bin + BW'(1);
      end
      default: w_state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt <= '0;
      r_bin <= '0;
      r_gz_rst <= 1'b1;
      r_re <= '0;
      r_im <= '0;
      r_res_bin <= '0;
      r_err <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt <= (w_state_n != r_state) ? '0 : r_cnt + CW'(1);
      r_bin <= w_bin_n;
      r_gz_rst <= w_state_n == S_CLEAR;
      if (w_cap || w_to) begin
        r_re <= w_cap ? bus.i_gz_re : '0;
        r_im <= w_cap ? bus.i_gz_im : '0;
        r_res_bin <= r_bin;
      end
      r_err[ERR_TO] <= r_err[ERR_TO] | w_to;
      r_err[ERR_OVR] <= r_err[ERR_OVR] | (bus.i_gz_valid && r_state != S_RUN);
    end
  end
`ifdef GZ_SCHED_MAGSQ_EN
  logic r_mag_ok;
  always_ff @(posedge i_clk)
    r_mag_ok <= i_rst_n && r_state == S_HOLD && !w_xfer;
  assign w_mag_ok = r_mag_ok;
  gz_mag_sq #(.OW(OW)) u_mag (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_re(r_re),
    .i_im(r_im),
    .o_mag(bus.o_res_mag)
  );
`else
  assign w_mag_ok = 1'b1;
  assign bus.o_res_mag = '0;
`endif
  assign bus.o_gz_rst = r_gz_rst;
  assign bus.o_gz_bin = r_bin;
  assign bus.o_res_valid = w_res_valid;
  assign bus.o_res_bin = r_res_bin;
  assign bus.o_res_re = r_re;
  assign bus.o_res_im = r_im;
  assign o_busy = r_state != S_IDLE;
  assign o_done = r_state == S_NEXT && w_last;
  assign o_err = r_err;
endmodule

// File: tb/tb_goertzel_bin_scheduler.sv
// tb_goertzel_bin_scheduler: vector table, random engine data/backpressure and corner sequences
module tb_goertzel_bin_scheduler;
  localparam int NBINS = 4, BW = 2, OW = 18, N = 126, TO = 16;
`ifdef GZ_SCHED_MAGSQ_EN
  localparam int MAG_LAT = 1;
`else
  localparam int MAG_LAT = 0;
`endif
  typedef struct { logic signed [OW-1:0] re, im; } res_t;
  typedef struct { bit rnd; int lat; int xfers; int dones; logic [1:0] err; } vec_t;
  logic clk, rst_n, start, cont, o_busy, o_done;
  logic [1:0] o_err;
  logic eng_valid = 0, inj_valid = 0, eng_en = 1, eng_fix = 0;
  logic rdy = 1, rdy_rand = 0, rdy_fixed = 1, prev_v = 0;
  logic signed [OW-1:0] eng_re = 0, eng_im = 0, inj_re = 0, inj_im = 0, fix_re = 0, fix_im = 0;
  int ecnt = -1, eng_lat = N + 3, cyc = 0, t_fall = 0, clr_len = 0;
  int sb_n = 0, n_xfer = 0, n_done = 0, checks = 0, errors = 0;
  res_t exp_q[$];
  res_t m_e;
  longint exp_mag;
  logic [63:0] snap;
  vec_t vecs[6];
  goertzel_bin_scheduler_if #(.BW(BW), .OW(OW)) bus();
  assign bus.i_gz_valid = eng_valid | inj_valid;
  assign bus.i_gz_re = inj_valid ? inj_re : eng_re;
  assign bus.i_gz_im = inj_valid ? inj_im : eng_im;
  assign bus.i_res_ready = rdy;
  goertzel_bin_scheduler #(.NBINS(NBINS), .BW(BW), .OW(OW), .N(N), .TO(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_continuous(cont),
    .bus(bus), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string nm, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask
  // engine model: one result a fixed latency after its reset falls
  always @(posedge clk) begin
    #1;
    if (bus.o_gz_rst) ecnt = -1;
    else ecnt++;
    eng_valid = eng_en && o_busy && ecnt == eng_lat;
    if (eng_valid) begin
      eng_re = eng_fix ? fix_re : OW'($urandom);
      eng_im = eng_fix ? fix_im : OW'($urandom);
      exp_q.push_back('{eng_re, eng_im});
    end
  end
  always @(posedge clk) begin
    #1;
    rdy = rdy_rand ? (($urandom & 1) != 0) : rdy_fixed;
  end
  // scoreboard: bin k of a sweep is the k-th transfer; a bin with no engine result reports zeros
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      clr_len = 0;
      prev_v = 0;
    end else begin
      if (bus.o_gz_rst && o_busy) clr_len++;
      else begin
        if (o_busy && clr_len > 0) begin
          chk("clear_len", clr_len, 2);
          chk("gz_bin", bus.o_gz_bin, sb_n % NBINS);
          t_fall = cyc;
        end
        clr_len = 0;
      end
      if (bus.o_res_valid && !prev_v)
        chk("latency", cyc - t_fall, exp_q.size() > 0 ? eng_lat + 1 + MAG_LAT : N + TO + MAG_LAT);
      if (bus.o_res_valid && bus.i_res_ready) begin
        if (exp_q.size() > 0) m_e = exp_q.pop_front();
        else m_e = '{0, 0};
`ifdef GZ_SCHED_MAGSQ_EN
        exp_mag = longint'(m_e.re) * m_e.re + longint'(m_e.im) * m_e.im;
`else
        exp_mag = 0;
`endif
        chk("res_bin", bus.o_res_bin, sb_n % NBINS);
        chk("res_re", bus.o_res_re, m_e.re);
        chk("res_im", bus.o_res_im, m_e.im);
        chk("res_mag", bus.o_res_mag, exp_mag);
        sb_n++;
        n_xfer++;
      end
      if (o_done) n_done++;
      prev_v = bus.o_res_valid;
    end
  end
  task automatic do_reset();
    @(posedge clk) #1;
    rst_n = 0;
    start = 0;
    cont = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gz_rst", bus.o_gz_rst, 1);
    chk("rst_gz_bin", bus.o_gz_bin, 0);
    chk("rst_valid", bus.o_res_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_err", o_err, 0);
    chk("rst_res", {bus.o_res_bin, bus.o_res_re, bus.o_res_im}, 0);
    chk("rst_mag", bus.o_res_mag, 0);
    exp_q.delete();
    @(posedge clk) #1;
    rst_n = 1;
    @(negedge clk);
    @(negedge clk);
    chk("rel_gz_rst", bus.o_gz_rst, 0);
  endtask
  task automatic start_sweep();
    @(posedge clk) #1;
    start = 1;
    sb_n = 0;
    n_xfer = 0;
    n_done = 0;
    @(posedge clk) #1;
    start = 0;
  endtask
  task automatic wait_idle();
    int k = 0;
    while (o_busy && k < 8000) begin
      @(negedge clk);
      k++;
    end
    chk("wait_idle", o_busy, 0);
  endtask
  task automatic wait_valid();
    int k = 0;
    while (!bus.o_res_valid && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("wait_valid", bus.o_res_valid, 1);
  endtask
  initial begin
    rst_n = 0;
    start = 0;
    cont = 0;
    vecs[0] = '{0, N + 3, NBINS, 1, 2'b00};
    vecs[1] = '{1, N + 3, NBINS, 1, 2'b00};
    vecs[2] = '{1, 0, NBINS, 1, 2'b00};
    vecs[3] = '{0, 7, NBINS, 1, 2'b00};
    vecs[4] = '{1, N + TO - 1, NBINS, 1, 2'b00};
    vecs[5] = '{0, -1, NBINS, 1, 2'b10};
    foreach (vecs[i]) begin
      do_reset();
      rdy_rand = vecs[i].rnd;
      rdy_fixed = 1;
      eng_en = vecs[i].lat >= 0;
      eng_lat = vecs[i].lat;
      start_sweep();
      wait_idle();
      chk($sformatf("v%0d_xfers", i), n_xfer, vecs[i].xfers);
      chk($sformatf("v%0d_done", i), n_done, vecs[i].dones);
      chk($sformatf("v%0d_err", i), o_err, vecs[i].err);
      chk($sformatf("v%0d_sb_empty", i), exp_q.size(), 0);
    end
    eng_en = 1;
    eng_lat = N + 3;
    rdy_rand = 0;
    // backpressure: result must hold still while ready is low
    do_reset();
    eng_fix = 1;
    fix_re = -5;
    fix_im = 7;
    rdy_fixed = 0;
    start_sweep();
    wait_valid();
    snap = {bus.o_res_bin, bus.o_res_re, bus.o_res_im};
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("bp_valid", bus.o_res_valid, 1);
      chk("bp_stable", {bus.o_res_bin, bus.o_res_re, bus.o_res_im}, snap);
    end
    chk("bp_re", bus.o_res_re, -5);
    chk("bp_im", bus.o_res_im, 7);
    rdy_fixed = 1;
    for (int k = 0; k < 10 && n_xfer == 0; k++) @(negedge clk);
    @(negedge clk);
    chk("bp_one_xfer", n_xfer, 1);
    chk("bp_valid_drop", bus.o_res_valid, 0);
    wait_idle();
    chk("bp_xfers", n_xfer, NBINS);
    eng_fix = 0;
    // overrun in HOLD, with a stray start that must be ignored
    do_reset();
    rdy_fixed = 0;
    start_sweep();
    wait_valid();
    snap = {bus.o_res_bin, bus.o_res_re, bus.o_res_im};
    @(posedge clk) #1;
    inj_valid = 1;
    inj_re = 123;
    inj_im = -77;
    start = 1;
    @(posedge clk) #1;
    inj_valid = 0;
    start = 0;
    @(negedge clk);
    @(negedge clk);
    chk("ovr_err", o_err, 2'b01);
    chk("ovr_held", {bus.o_res_bin, bus.o_res_re, bus.o_res_im}, snap);
    chk("ovr_valid", bus.o_res_valid, 1);
    rdy_fixed = 1;
    wait_idle();
    chk("ovr_xfers", n_xfer, NBINS);
    chk("ovr_done", n_done, 1);
    // continuous: two sweeps, dropping continuous during the second
    do_reset();
    rdy_rand = 1;
    cont = 1;
    start_sweep();
    for (int k = 0; k < 4000 && n_done == 0; k++) @(negedge clk);
    chk("cont_first_done", n_done, 1);
    @(posedge clk) #1;
    cont = 0;
    wait_idle();
    chk("cont_xfers", n_xfer, 2 * NBINS);
    chk("cont_done", n_done, 2);
    rdy_rand = 0;
    // reset in the middle of bin 2, then a fresh sweep from bin 0
    do_reset();
    eng_fix = 1;
    fix_re = 3;
    fix_im = -4;
    start_sweep();
    for (int k = 0; k < 2000 && !(bus.o_gz_bin == 2 && !bus.o_gz_rst && o_busy); k++) @(negedge clk);
    chk("mid_bin", bus.o_gz_bin, 2);
    repeat (10) @(negedge clk);
    chk("mid_xfers", n_xfer, 2);
    do_reset();
    chk("mid_no_done", n_done, 0);
    chk("mid_idle", o_busy, 0);
    start_sweep();
    wait_idle();
    chk("mid_restart_xfers", n_xfer, NBINS);
    chk("mid_restart_done", n_done, 1);
    chk("mid_err", o_err, 0);
    eng_fix = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
